// File: rtl/pcm_i2s_out_pkg.sv
// Shared widths, I2S framing constants and serialiser state encoding
// for the PCM-to-I2S output stage of the HiFi-GAN generator.
package pcm_i2s_out_pkg;

    localparam int Q15_W     = 16;
    localparam int I2S_SLOTS = 32;
    localparam int I2S_CH_W  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pcm_i2s_out_sync_fifo.sv
// First-word-fall-through sample buffer with registered full/empty/level,
// so nothing downstream sees a combinational path through the pointers.
module sync_fifo
    import pcm_i2s_out_pkg::*;
#(
    parameter int DATA_W     = Q15_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             rd_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              full_q, empty_q;
    logic              do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // Flags are derived from the next level so they stay registered yet exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            full_q  <= (level_d == LW'(FIFO_DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign level_o   = level_q;

endmodule

// File: rtl/pcm_i2s_out.sv
// Buffers Q15 samples and serialises each as a mono-duplicated standard I2S
// frame (L = R = sample, one-bclk data delay) with internally divided bclk/lrclk.
module pcm_i2s_out
    import pcm_i2s_out_pkg::*;
#(
    parameter int DATA_W     = Q15_W,
    parameter int FIFO_DEPTH = 16,
    parameter int BCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          underrun_clr
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int K_W   = $clog2(I2S_SLOTS);
    localparam logic [K_W-1:0] K_LAST = K_W'(I2S_SLOTS - 1);

    state_e                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   bclk_q, bclk_d;
    logic                   lrclk_q, lrclk_d;
    logic                   sdata_q, sdata_d;
    logic [K_W-1:0]         k_q, k_d, k_next;
    logic [I2S_SLOTS-1:0]   sh_q, sh_d, load_w;
    logic                   underrun_q, underrun_d;
    logic                   ur_set, div_wrap;

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]      fifo_rd;

    assign s_ready   = !fifo_full && !rst;
    assign fifo_push = s_valid && s_ready;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (fifo_push),
        .wr_data_i (s_data),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    // k_q parks at the last slot while idle so the first falling edge lands on slot 0.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bclk_d   = bclk_q;
        lrclk_d  = lrclk_q;
        sdata_d  = sdata_q;
        k_d      = k_q;
        sh_d     = sh_q;
        fifo_pop = 1'b0;
        ur_set   = 1'b0;
        load_w   = '0;
        k_next   = k_q + 1'b1;
        div_wrap = (div_q == DIV_W'(BCLK_DIV - 1));

        unique case (state_q)
            ST_IDLE: begin
                div_d   = '0;
                bclk_d  = 1'b0;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
                k_d     = K_LAST;
                sh_d    = '0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                div_d = div_wrap ? '0 : div_q + 1'b1;
                if (div_wrap) begin
                    bclk_d = !bclk_q;
                    if (bclk_q) begin
                        if (k_next == K_W'(1)) begin
                            // Frame boundary: stop here if disabled, slot 0 has already flushed bit 0.
                            if (!enable) begin
                                state_d = ST_IDLE;
                                div_d   = '0;
                                bclk_d  = 1'b0;
                                lrclk_d = 1'b0;
                                sdata_d = 1'b0;
                                k_d     = K_LAST;
                                sh_d    = '0;
                            end else begin
                                fifo_pop = !fifo_empty;
                                ur_set   = fifo_empty;
                                load_w   = fifo_empty ? '0 : {fifo_rd, fifo_rd};
                                sdata_d  = load_w[I2S_SLOTS-1];
                                sh_d     = {load_w[I2S_SLOTS-2:0], 1'b0};
                                k_d      = k_next;
                                lrclk_d  = 1'b0;
                            end
                        end else begin
                            sdata_d = sh_q[I2S_SLOTS-1];
                            sh_d    = {sh_q[I2S_SLOTS-2:0], 1'b0};
                            k_d     = k_next;
                            lrclk_d = (k_next >= K_W'(I2S_SLOTS / 2));
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        underrun_d = ur_set ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            k_q        <= K_LAST;
            sh_q       <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            k_q        <= k_d;
            sh_q       <= sh_d;
            underrun_q <= underrun_d;
        end
    end

    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

endmodule
